// File: rtl/conv_window_gen_if.sv
// Stream bundle for the 3x3 window generator.
// The pixel stream enters on one side and the window stream leaves on the other.
// master is the generator side; slave is the upstream/downstream environment side.
interface conv_window_gen_if #(
  parameter int unsigned PIX_W = 8
);
  logic [PIX_W-1:0]   pix_in;
  logic               pix_valid;
  logic               pix_ready;
  logic [9*PIX_W-1:0] win_out;
  logic               win_valid;
  logic               win_ready;
  logic               frame_done;

  modport master (
    input  pix_in, pix_valid, win_ready,
    output pix_ready, win_out, win_valid, frame_done
  );

  modport slave (
    output pix_in, pix_valid, win_ready,
    input  pix_ready, win_out, win_valid, frame_done
  );
endinterface

// File: rtl/conv_window_gen.sv
// Raster pixel stream to 3x3 window generator with two line buffers.
// Emits only fully-valid windows (no padding) on a valid/ready handshake.
module conv_window_gen #(
  parameter int unsigned IMG_W = 16,
  parameter int unsigned IMG_H = 16,
  parameter int unsigned PIX_W = 8
) (
  input logic               clk,
  input logic               rst,
  conv_window_gen_if.master bus
);

  localparam int unsigned CW    = $clog2(IMG_W);
  localparam int unsigned RW    = $clog2(IMG_H);
  localparam int unsigned WIN_W = 9 * PIX_W;

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_nxt;
  logic             win_valid_q;
  logic             frame_done_q;
  logic             accept;
  logic             emit;
  logic             col_last;
  logic             row_last;

  assign bus.pix_ready  = !win_valid_q || bus.win_ready;
  assign bus.win_out    = win_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;

  assign accept   = bus.pix_valid && bus.pix_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));

  // Shift the window one column left; new right column is {LB1, LB0, pix_in}.
  always_comb begin
    win_nxt = win_q;
    for (int r = 0; r < 3; r++) begin
      win_nxt[PIX_W*(3*r)   +: PIX_W] = win_q[PIX_W*(3*r+1) +: PIX_W];
      win_nxt[PIX_W*(3*r+1) +: PIX_W] = win_q[PIX_W*(3*r+2) +: PIX_W];
    end
    win_nxt[PIX_W*2 +: PIX_W] = lb1[col];
    win_nxt[PIX_W*5 +: PIX_W] = lb0[col];
    win_nxt[PIX_W*8 +: PIX_W] = bus.pix_in;
  end

  // Line buffers are never cleared: rows 0-1 rewrite them before any emission.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= bus.pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (accept) begin
        win_q        <= win_nxt;
        win_valid_q  <= emit;
        frame_done_q <= emit && row_last && col_last;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end else if (win_valid_q && bus.win_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on a 4x4 image.
// Expected windows come from a frame-level model that slices the image directly.
module tb_conv_window_gen;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int PW   = 8;
  localparam int NPIX = W * H;
  localparam int WB   = 9 * PW;

  typedef struct packed {
    logic [WB-1:0] win;
    logic          fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv_window_gen_if #(.PIX_W(PW)) bus();
  conv_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t          q[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            last_acc = -10;
  int            popped = 0;
  int            fd_cnt = 0;
  bit            rnd_ready = 1'b0;
  bit            prev_v = 1'b0;
  bit            prev_xfer = 1'b0;
  logic [WB-1:0] prev_w = '0;

  task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every 3x3 window of a frame, in raster order of its bottom-right pixel.
  function automatic void push_frame(input int px[NPIX]);
    exp_t e;
    for (int br = 2; br < H; br++) begin
      for (int bc = 2; bc < W; bc++) begin
        e.win = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            e.win[PW*(3*r+c) +: PW] = PW'(px[(br-2+r)*W + (bc-2+c)]);
        e.fd = (br == H-1) && (bc == W-1);
        q.push_back(e);
      end
    end
  endfunction

  function automatic logic [WB-1:0] mk_win(input int s[9]);
    logic [WB-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[PW*k +: PW] = PW'(s[k]);
    return w;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst && bus.pix_valid && bus.pix_ready) last_acc = cyc;
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1 bus.win_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare each newly presented window against the scoreboard head.
  always @(negedge clk) begin
    bit first;
    if (rst) begin
      prev_v    = 1'b0;
      prev_xfer = 1'b0;
    end else begin
      first = bus.win_valid && (!prev_v || prev_xfer);
      check("pix_ready", WB'(bus.pix_ready), WB'(!bus.win_valid || bus.win_ready));
      if (bus.frame_done) fd_cnt++;
      if (first) begin
        check("latency", WB'(cyc), WB'(last_acc));
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_window: got %h expected none", bus.win_out);
        end else begin
          check("win_out", bus.win_out, q[0].win);
          check("frame_done", WB'(bus.frame_done), WB'(q[0].fd));
        end
      end else begin
        check("frame_done_idle", WB'(bus.frame_done), WB'(0));
        if (bus.win_valid) check("win_hold", bus.win_out, prev_w);
      end
      if (bus.win_valid && bus.win_ready && q.size() != 0) begin
        void'(q.pop_front());
        popped++;
      end
      prev_v    = bus.win_valid;
      prev_xfer = bus.win_valid && bus.win_ready;
      prev_w    = bus.win_out;
    end
  end

  task automatic send_pix(input int v);
    bit acc;
    int n;
    bus.pix_in    = PW'(v);
    bus.pix_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = bus.pix_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout: got stalled expected accept of pixel %0d", v);
    end
  endtask

  task automatic send_frame(input int px[NPIX], input bit gaps);
    for (int i = 0; i < NPIX; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.pix_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
      send_pix(px[i]);
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || bus.win_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", WB'(q.size()), WB'(0));
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int ramp[NPIX];
    int ramp2[NPIX];
    int rnd[NPIX];
    int first_s[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int fd0;
    bit seen;
    for (int i = 0; i < NPIX; i++) begin
      ramp[i]  = i;
      ramp2[i] = i + NPIX;
    end
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
    bus.win_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_win_valid", WB'(bus.win_valid), WB'(0));
    check("rst_frame_done", WB'(bus.frame_done), WB'(0));
    check("rst_pix_ready", WB'(bus.pix_ready), WB'(1));
    check("rst_win_out", bus.win_out, WB'(0));
    @(posedge clk);
    #1;

    // Full frame, no stalls
    push_frame(ramp);
    send_frame(ramp, 1'b0);
    wait_drain();

    // Backpressure on the first window
    push_frame(ramp);
    fork
      send_frame(ramp, 1'b0);
      begin
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
          @(posedge clk);
          #1;
          seen = bus.win_valid;
        end
        check("bp_first_seen", WB'(seen), WB'(1));
        bus.win_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("bp_win_out", bus.win_out, mk_win(first_s));
          check("bp_pix_ready", WB'(bus.pix_ready), WB'(0));
          check("bp_win_valid", WB'(bus.win_valid), WB'(1));
        end
        @(posedge clk);
        #1 bus.win_ready = 1'b1;
      end
    join
    wait_drain();

    // Back-to-back frames
    fd0 = fd_cnt;
    push_frame(ramp);
    push_frame(ramp2);
    for (int i = 0; i < NPIX; i++) send_pix(ramp[i]);
    for (int i = 0; i < NPIX; i++) send_pix(ramp2[i]);
    bus.pix_valid = 1'b0;
    wait_drain();
    check("b2b_frame_done_cnt", WB'(fd_cnt - fd0), WB'(2));

    // Reset mid-frame, then a fresh frame
    for (int i = 0; i < 7; i++) send_pix(i);
    bus.pix_valid = 1'b0;
    pulse_reset(1);
    @(negedge clk);
    check("midrst_win_valid", WB'(bus.win_valid), WB'(0));
    @(posedge clk);
    #1;
    push_frame(ramp);
    send_frame(ramp, 1'b0);
    wait_drain();

    // Random gaps and random downstream ready
    rnd_ready = 1'b1;
    push_frame(ramp);
    send_frame(ramp, 1'b1);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NPIX; i++) rnd[i] = int'($urandom_range(0, 255));
      push_frame(rnd);
      send_frame(rnd, 1'b1);
    end
    wait_drain();
    rnd_ready = 1'b0;
    @(posedge clk);
    #2 bus.win_ready = 1'b1;
    repeat (3) @(posedge clk);

    check("window_count", WB'(popped), WB'(36));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
